fft_spectrum_buf: RTL and testbench

//  Captures one FFT magnitude frame from fft_top (sop/eop/valid framed, 32-bit modulus).

---
 rtl/fft_spectrum_buf_if.sv | 38 +++
 rtl/fft_spectrum_buf.sv | 156 +++++++++++++++
 tb/tb_fft_spectrum_buf.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_spectrum_buf_if.sv
// ---------------------------------------------------------------------------
// fft_spectrum_buf_if
//   Bundles the FFT magnitude stream, the renderer swap/read port and the
//   status outputs of fft_spectrum_buf.
//   master : producer side (FFT stream + renderer), drives the inputs
//   slave  : the spectrum buffer itself
//   Signals:
//     fft_data/fft_sop/fft_eop/fft_valid  32-bit modulus stream, sop/eop framed
//     swap_req                            commit pulse from the renderer (vsync)
//     rd_en/rd_addr -> rd_data            1-cycle latency bar-height read
//     frame_ready/disp_valid/drop_cnt     status
// ---------------------------------------------------------------------------
interface fft_spectrum_buf_if #(
  parameter int AW = 9,
  parameter int HW = 10
);
  logic [31:0]   fft_data;
  logic          fft_sop;
  logic          fft_eop;
  logic          fft_valid;
  logic          swap_req;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [HW-1:0] rd_data;
  logic          frame_ready;
  logic          disp_valid;
  logic [7:0]    drop_cnt;

  modport master (
    output fft_data, fft_sop, fft_eop, fft_valid, swap_req, rd_en, rd_addr,
    input  rd_data, frame_ready, disp_valid, drop_cnt
  );

  modport slave (
    input  fft_data, fft_sop, fft_eop, fft_valid, swap_req, rd_en, rd_addr,
    output rd_data, frame_ready, disp_valid, drop_cnt
  );
endinterface

// File: rtl/fft_spectrum_buf.sv
// ---------------------------------------------------------------------------
// fft_spectrum_buf
//   Captures one FFT magnitude frame, scales each bin to a clamped bar height
//   and stores it in a ping-pong bank pair. The renderer reads the committed
//   (display) bank while the next frame fills the write bank; swap_req
//   commits a completed frame at vsync.
//   Ports:
//     sys_clk  single clock
//     rst      asynchronous, active-high reset
//     bus      fft_spectrum_buf_if.slave (stream in, read port, status out)
// ---------------------------------------------------------------------------
module fft_spectrum_buf #(
  parameter int FFT_N = 1024,
  parameter int NBINS = 512,
  parameter int HW    = 10,
  parameter int SHIFT = 12,
  parameter int MAX_H = 720
) (
  input  logic                sys_clk,
  input  logic                rst,
  fft_spectrum_buf_if.slave   bus
);
  localparam int AW = $clog2(NBINS);
  localparam int IW = $clog2(FFT_N);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  idx, idx_nxt;      // index of the next expected beat
  logic [IW-1:0]  wr_idx;
  logic           we;
  logic           wbank;             // bank targeted by this cycle's write
  logic           wr_bank, rd_bank;
  logic           do_swap;
  logic           drop_inc;
  logic           disp_valid;
  logic [7:0]     drop_cnt;
  logic [HW-1:0]  rd_data;

  logic [HW-1:0]  mem [0:2**(AW+1)-1];

  // Bar-height scaling: shift, then clamp to the display height.
  logic [31:0]    shifted;
  logic [HW-1:0]  height;
  assign shifted = bus.fft_data >> SHIFT;
  assign height  = (shifted > 32'(MAX_H)) ? HW'(MAX_H) : shifted[HW-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_idx    = idx;
    we        = 1'b0;
    wbank     = wr_bank;
    do_swap   = 1'b0;
    drop_inc  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.fft_valid && bus.fft_sop) begin
          we        = 1'b1;
          wr_idx    = '0;
          idx_nxt   = IW'(1);
          state_nxt = S_CAPT;
        end
      end
      S_CAPT: begin
        if (bus.fft_valid) begin
          if (bus.fft_sop) begin
            // Restart: the partial frame is abandoned and counted as lost.
            we       = 1'b1;
            wr_idx   = '0;
            idx_nxt  = IW'(1);
            drop_inc = 1'b1;
          end else if (idx == IW'(FFT_N - 1)) begin
            // Last legal beat: only eop here completes the frame.
            if (bus.fft_eop) begin
              we        = 1'b1;
              state_nxt = S_DONE;
            end else begin
              drop_inc  = 1'b1;
              state_nxt = S_IDLE;
            end
          end else if (bus.fft_eop) begin
            drop_inc  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            we      = 1'b1;
            idx_nxt = idx + IW'(1);
          end
        end
      end
      S_DONE: begin
        if (bus.swap_req) begin
          do_swap   = 1'b1;
          state_nxt = S_IDLE;
          if (bus.fft_valid && bus.fft_sop) begin
            // Swap wins; the new frame's bin 0 lands in the freed bank.
            we        = 1'b1;
            wbank     = ~wr_bank;
            wr_idx    = '0;
            idx_nxt   = IW'(1);
            state_nxt = S_CAPT;
          end
        end else if (bus.fft_valid && bus.fft_sop) begin
          // Held frame is kept; the incoming one is lost.
          drop_inc = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b1;
      disp_valid <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (do_swap) begin
        rd_bank    <= wr_bank;
        wr_bank    <= ~wr_bank;
        disp_valid <= 1'b1;
      end
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // NOTE: the bank RAM has no reset; disp_valid gates what the renderer can
  // see, so stale contents are never observable.
  always_ff @(posedge sys_clk) begin
    if (we && (32'(wr_idx) < NBINS)) mem[{wbank, wr_idx[AW-1:0]}] <= height;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (!disp_valid) begin
      rd_data <= '0;
    end else if (bus.rd_en) begin
      rd_data <= (32'(bus.rd_addr) < NBINS) ? mem[{rd_bank, bus.rd_addr}] : '0;
    end
  end

  assign bus.rd_data     = rd_data;
  assign bus.frame_ready = (state == S_DONE);
  assign bus.disp_valid  = disp_valid;
  assign bus.drop_cnt    = drop_cnt;
endmodule

// File: tb/tb_fft_spectrum_buf.sv
// ---------------------------------------------------------------------------
// tb_fft_spectrum_buf
//   Directed bench for fft_spectrum_buf: reset, full frame + swap, scaling
//   and clamp, malformed frames, overrun, sop coincident with swap, reset
//   mid-frame and drop counter saturation.
// ---------------------------------------------------------------------------
module tb_fft_spectrum_buf;
  localparam int FFT_N = 1024;
  localparam int NBINS = 512;
  localparam int HW    = 10;
  localparam int AW    = 9;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  fft_spectrum_buf_if #(.AW(AW), .HW(HW)) bus ();

  fft_spectrum_buf #(
    .FFT_N(FFT_N), .NBINS(NBINS), .HW(HW), .SHIFT(12), .MAX_H(720)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // mode 0: bin<<12 (height = bin); mode 1: scaling table; mode 2: reversed.
  function automatic logic [31:0] beat_data(input int mode, input int b);
    case (mode)
      0: return 32'(b) << 12;
      1: case (b)
           0: return 32'hFFFF_FFFF;
           1: return 32'd4095;
           2: return 32'd720 << 12;
           3: return 32'd721 << 12;
           4: return (32'd719 << 12) | 32'd4095;
           5: return 32'd4096;
           default: return 32'd0;
         endcase
      2: return 32'(511 - (b % 512)) << 12;
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle_bus();
    bus.fft_valid = 1'b0;
    bus.fft_sop   = 1'b0;
    bus.fft_eop   = 1'b0;
    bus.fft_data  = '0;
    bus.swap_req  = 1'b0;
  endtask

  // eop_at < 0 means no eop; fr_at_eop samples frame_ready while eop is driven.
  task automatic send_frame(input int n_beats, input int eop_at, input int mode,
                            input bit swap_on_sop, output logic fr_at_eop);
    fr_at_eop = 1'bx;
    for (int b = 0; b < n_beats; b++) begin
      @(negedge sys_clk);
      bus.fft_valid = 1'b1;
      bus.fft_sop   = (b == 0);
      bus.fft_eop   = (b == eop_at);
      bus.fft_data  = beat_data(mode, b);
      bus.swap_req  = swap_on_sop && (b == 0);
      if (b == eop_at) fr_at_eop = bus.frame_ready;
    end
    @(negedge sys_clk);
    idle_bus();
  endtask

  task automatic pulse_swap();
    @(negedge sys_clk);
    bus.swap_req = 1'b1;
    @(negedge sys_clk);
    bus.swap_req = 1'b0;
  endtask

  task automatic read_bin(input logic [AW-1:0] a, output logic [HW-1:0] v);
    @(negedge sys_clk);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    @(negedge sys_clk);
    bus.rd_en   = 1'b0;
    v = bus.rd_data;
  endtask

  task automatic test_reset();
    logic [HW-1:0] v;
    rst = 1'b1;
    idle_bus();
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    read_bin(9'd5, v);
    n_vec++; if (v !== 10'd0) begin n_err++; $display("FAIL reset_rd_data: got %0d expected 0", v); end
    n_vec++; if (bus.disp_valid !== 1'b0) begin n_err++; $display("FAIL reset_disp_valid: got %b expected 0", bus.disp_valid); end
    n_vec++; if (bus.frame_ready !== 1'b0) begin n_err++; $display("FAIL reset_frame_ready: got %b expected 0", bus.frame_ready); end
    n_vec++; if (bus.drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop_cnt: got %0d expected 0", bus.drop_cnt); end
  endtask

  task automatic test_full_frame();
    logic fr;
    logic [HW-1:0] v;
    send_frame(FFT_N, FFT_N - 1, 0, 1'b0, fr);
    n_vec++; if (fr !== 1'b0) begin n_err++; $display("FAIL full_fr_during_eop: got %b expected 0", fr); end
    n_vec++; if (bus.frame_ready !== 1'b1) begin n_err++; $display("FAIL full_fr_after_eop: got %b expected 1", bus.frame_ready); end
    n_vec++; if (bus.disp_valid !== 1'b0) begin n_err++; $display("FAIL full_disp_before_swap: got %b expected 0", bus.disp_valid); end
    pulse_swap();
    n_vec++; if (bus.disp_valid !== 1'b1) begin n_err++; $display("FAIL full_disp_after_swap: got %b expected 1", bus.disp_valid); end
    n_vec++; if (bus.frame_ready !== 1'b0) begin n_err++; $display("FAIL full_fr_after_swap: got %b expected 0", bus.frame_ready); end
    read_bin(9'd100, v);
    n_vec++; if (v !== 10'd100) begin n_err++; $display("FAIL full_rd_100: got %0d expected 100", v); end
    read_bin(9'd511, v);
    n_vec++; if (v !== 10'd511) begin n_err++; $display("FAIL full_rd_511: got %0d expected 511", v); end
    // rd_en low with a new address: rd_data must hold.
    @(negedge sys_clk);
    bus.rd_addr = 9'd3;
    @(negedge sys_clk);
    n_vec++; if (bus.rd_data !== 10'd511) begin n_err++; $display("FAIL full_rd_hold: got %0d expected 511", bus.rd_data); end
  endtask

  task automatic test_scaling();
    logic fr;
    logic [HW-1:0] v;
    int exp_h [6] = '{720, 0, 720, 720, 719, 1};
    send_frame(FFT_N, FFT_N - 1, 1, 1'b0, fr);
    pulse_swap();
    for (int i = 0; i < 6; i++) begin
      read_bin(AW'(i), v);
      n_vec++; if (v !== HW'(exp_h[i])) begin n_err++; $display("FAIL scale_bin%0d: got %0d expected %0d", i, v, exp_h[i]); end
    end
  endtask

  task automatic test_malformed();
    logic fr;
    logic [HW-1:0] v;
    // Early eop at beat 500.
    send_frame(501, 500, 0, 1'b0, fr);
    n_vec++; if (bus.drop_cnt !== 8'd1) begin n_err++; $display("FAIL early_eop_drop: got %0d expected 1", bus.drop_cnt); end
    n_vec++; if (bus.frame_ready !== 1'b0) begin n_err++; $display("FAIL early_eop_fr: got %b expected 0", bus.frame_ready); end
    // swap_req outside DONE is ignored; display still holds the scaling frame.
    pulse_swap();
    read_bin(9'd2, v);
    n_vec++; if (v !== 10'd720) begin n_err++; $display("FAIL early_eop_display: got %0d expected 720", v); end
    read_bin(9'd5, v);
    n_vec++; if (v !== 10'd1) begin n_err++; $display("FAIL early_eop_display5: got %0d expected 1", v); end
    // Full-length frame with no eop.
    send_frame(FFT_N, -1, 0, 1'b0, fr);
    n_vec++; if (bus.drop_cnt !== 8'd2) begin n_err++; $display("FAIL no_eop_drop: got %0d expected 2", bus.drop_cnt); end
    n_vec++; if (bus.frame_ready !== 1'b0) begin n_err++; $display("FAIL no_eop_fr: got %b expected 0", bus.frame_ready); end
  endtask

  task automatic test_restart();
    logic fr;
    logic [HW-1:0] v;
    send_frame(300, -1, 2, 1'b0, fr);
    send_frame(FFT_N, FFT_N - 1, 0, 1'b0, fr);
    n_vec++; if (bus.drop_cnt !== 8'd3) begin n_err++; $display("FAIL restart_drop: got %0d expected 3", bus.drop_cnt); end
    n_vec++; if (bus.frame_ready !== 1'b1) begin n_err++; $display("FAIL restart_fr: got %b expected 1", bus.frame_ready); end
    pulse_swap();
    read_bin(9'd200, v);
    n_vec++; if (v !== 10'd200) begin n_err++; $display("FAIL restart_rd_200: got %0d expected 200", v); end
  endtask

  task automatic test_overrun();
    logic fr;
    logic [HW-1:0] v;
    send_frame(FFT_N, FFT_N - 1, 2, 1'b0, fr);  // frame 1: reversed
    send_frame(FFT_N, FFT_N - 1, 0, 1'b0, fr);  // frame 2: lost
    n_vec++; if (bus.drop_cnt !== 8'd4) begin n_err++; $display("FAIL overrun_drop: got %0d expected 4", bus.drop_cnt); end
    n_vec++; if (bus.frame_ready !== 1'b1) begin n_err++; $display("FAIL overrun_fr: got %b expected 1", bus.frame_ready); end
    pulse_swap();
    read_bin(9'd100, v);
    n_vec++; if (v !== 10'd411) begin n_err++; $display("FAIL overrun_rd_100: got %0d expected 411", v); end
  endtask

  task automatic test_back_to_back();
    logic fr;
    logic [HW-1:0] v;
    send_frame(FFT_N, FFT_N - 1, 0, 1'b0, fr);  // held frame: height = bin
    send_frame(FFT_N, FFT_N - 1, 2, 1'b1, fr);  // swap on its sop
    n_vec++; if (bus.frame_ready !== 1'b1) begin n_err++; $display("FAIL b2b_fr: got %b expected 1", bus.frame_ready); end
    n_vec++; if (bus.drop_cnt !== 8'd4) begin n_err++; $display("FAIL b2b_drop: got %0d expected 4", bus.drop_cnt); end
    read_bin(9'd100, v);
    n_vec++; if (v !== 10'd100) begin n_err++; $display("FAIL b2b_rd_first: got %0d expected 100", v); end
    pulse_swap();
    read_bin(9'd100, v);
    n_vec++; if (v !== 10'd411) begin n_err++; $display("FAIL b2b_rd_second: got %0d expected 411", v); end
    read_bin(9'd0, v);
    n_vec++; if (v !== 10'd511) begin n_err++; $display("FAIL b2b_rd_bin0: got %0d expected 511", v); end
  endtask

  task automatic test_reset_mid();
    logic fr;
    logic [HW-1:0] v;
    send_frame(FFT_N, FFT_N - 1, 0, 1'b0, fr);
    send_frame(200, -1, 2, 1'b0, fr);  // sop in DONE -> drop 5
    n_vec++; if (bus.drop_cnt !== 8'd5) begin n_err++; $display("FAIL mid_pre_drop: got %0d expected 5", bus.drop_cnt); end
    @(negedge sys_clk);
    rst = 1'b1;
    #1;
    n_vec++; if (bus.frame_ready !== 1'b0) begin n_err++; $display("FAIL mid_frame_ready: got %b expected 0", bus.frame_ready); end
    n_vec++; if (bus.disp_valid !== 1'b0) begin n_err++; $display("FAIL mid_disp_valid: got %b expected 0", bus.disp_valid); end
    n_vec++; if (bus.drop_cnt !== 8'd0) begin n_err++; $display("FAIL mid_drop_cnt: got %0d expected 0", bus.drop_cnt); end
    n_vec++; if (bus.rd_data !== 10'd0) begin n_err++; $display("FAIL mid_rd_data: got %0d expected 0", bus.rd_data); end
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    read_bin(9'd100, v);
    n_vec++; if (v !== 10'd0) begin n_err++; $display("FAIL mid_rd_after: got %0d expected 0", v); end
  endtask

  task automatic test_drop_saturate();
    // Repeated single sop beats: each one after the first restarts a frame.
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      bus.fft_valid = 1'b1;
      bus.fft_sop   = 1'b1;
      bus.fft_eop   = 1'b0;
      bus.fft_data  = '0;
    end
    @(negedge sys_clk);
    idle_bus();
    n_vec++; if (bus.drop_cnt !== 8'd255) begin n_err++; $display("FAIL drop_saturate: got %0d expected 255", bus.drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_scaling();
    test_malformed();
    test_restart();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_drop_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
